l2_cache_control: RTL
=====================

L2_CACHE_CONTROL -- requirements
Module: l2_cache_control

Interface
REQ-001 Parameter num_ways, default 8: ways per set; all per-way ports are unpacked arrays [num_ways].
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 mem_read, mem_write  in  1 each  upstream line request; held until mem_resp; never both high.
REQ-005 mem_resp  out  1  one-cycle request-complete pulse.
REQ-006 pmem_read, pmem_write  out  1 each  memory request; held until pmem_resp.
REQ-007 pmem_resp  in  1  memory completion pulse.
REQ-008 hit, dirty_out, valid_out  in  1 per way  datapath array status.
REQ-009 lru_out  in  num_ways  replacement pointer for the indexed set, one-hot or zero.
REQ-010 lru_in  out  num_ways;  ld_lru, rd_lru  out  1 each.
REQ-011 ld_dirty, ld_valid, ld_tag, rd_data, rd_dirty, rd_valid, rd_tag, dirty_in, valid_in, datain_sel  out  1 per way.
REQ-012 byte_enable  out  32 per way  data-array write enables.
REQ-013 mem_addr_sel  out  1  0 = request address, 1 = victim writeback address.

Function
REQ-014 States: IDLE, CHECK, WB, FILL, REREAD; unlisted outputs are 0 in every state.
REQ-015 IDLE: all rd_* = 1; on mem_read or mem_write -> CHECK, else stay.
REQ-016 CHECK, any hit[w] with read: mem_resp = 1 -> IDLE; array latency = 1 cycle, so a read hit completes 2 cycles after request.
REQ-017 CHECK, hit[w] with write: byte_enable[w] = 32'hFFFFFFFF, datain_sel[w] = 0, ld_dirty[w] = 1, dirty_in[w] = 1, mem_resp = 1 -> IDLE.
REQ-018 CHECK, miss: victim = lowest-index way with valid_out = 0; if none, victim = lru_out; victim latched into a one-hot register for the rest of the miss.
REQ-019 CHECK, miss: next state is WB if victim valid and dirty, else FILL.
REQ-020 WB: mem_addr_sel = 1, pmem_write = 1; on pmem_resp: ld_dirty[victim] = 1, dirty_in = 0 -> FILL.
REQ-021 FILL: mem_addr_sel = 0, pmem_read = 1; on pmem_resp: byte_enable[victim] = all ones, datain_sel[victim] = 1, ld_tag, ld_valid, and ld_dirty on the victim, valid_in = 1, dirty_in = 0 -> REREAD.
REQ-022 On the same pmem_resp cycle: ld_lru = 1, lru_in = victim rotated left by one (way num_ways-1 wraps to way 0).
REQ-023 Lookups and hits never write the LRU array; replacement is round-robin per set.
REQ-024 REREAD: all rd_* = 1 -> CHECK, which then hits and finishes via REQ-016/017.
REQ-025 In WB and FILL all rd_* = 0, so array outputs hold and the datapath victim address stays stable.
REQ-026 More than one hit bit in CHECK is illegal; an assertion flags it and the lowest index is used.
REQ-027 pmem_read and pmem_write are never high in the same cycle; neither is high outside WB/FILL.

Reset
REQ-028 rst takes priority in every state, including WB/FILL mid-transfer: next state IDLE, victim register 0, all outputs 0 in the reset cycle.
REQ-029 From the first cycle after reset (state IDLE), rd_* = 1 and all other outputs are 0.

Verification
REQ-030 Read to empty set, index 2, tag 0x1234: CHECK miss, victim way 0, FILL with pmem_read, no pmem_write -> lru_in = 8'b00000010, REREAD, hit, mem_resp 3 cycles after pmem_resp.
REQ-031 Read hit after REQ-030: mem_resp exactly 2 cycles after mem_read rises; no pmem activity; ld_lru = 0.
REQ-032 Write hit to way 0: byte_enable[0] = 32'hFFFFFFFF, datain_sel[0] = 0, dirty_in[0] = 1 and mem_resp in the same cycle.
REQ-033 Nine distinct tags to one set, all written dirty; ninth access with lru_out = 8'b00000001 -> WB with mem_addr_sel = 1, then FILL of way 0, lru_in = 8'b00000010.
REQ-034 rst asserted while in FILL with pmem_read high -> next cycle IDLE, pmem_read = 0, mem_resp = 0; a new request completes normally.
REQ-035 pmem_resp delayed 0, 1 and 20 cycles in WB and FILL: the request stays held and no array load occurs before pmem_resp.

Source files
------------

// File: rtl/l2_cache_control_if.sv
// Upstream request/response and backing-memory handshake for the L2 cache
// controller.
//   mem_read / mem_write : line request from the level above, held until mem_resp
//   mem_resp             : one-cycle completion pulse back to the requester
//   pmem_read/pmem_write : line request to backing memory, held until pmem_resp
//   pmem_resp            : one-cycle completion pulse from backing memory
// The slave modport is the controller's view; the master modport is the view
// of the surrounding requester plus memory model.
interface l2_cache_control_if;
    logic mem_read;
    logic mem_write;
    logic mem_resp;
    logic pmem_read;
    logic pmem_write;
    logic pmem_resp;

    modport master (
        output mem_read, mem_write, pmem_resp,
        input  mem_resp, pmem_read, pmem_write
    );

    modport slave (
        input  mem_read, mem_write, pmem_resp,
        output mem_resp, pmem_read, pmem_write
    );
endinterface

// File: rtl/l2_cache_control.sv
// Control FSM for an N-way set-associative L2 cache with write-back,
// write-allocate policy and per-set round-robin replacement.
//
// Ports:
//   clk, rst     : single clock, synchronous active-high reset
//   bus          : request/response and backing-memory handshake (slave side)
//   hit, dirty_out, valid_out [num_ways] : tag/status array outputs
//   lru_out      : replacement pointer of the indexed set (one-hot or zero)
//   lru_in, ld_lru, rd_lru               : replacement array control
//   ld_*/rd_*/dirty_in/valid_in/datain_sel [num_ways] : per-way array control
//   byte_enable [num_ways]               : data-array write enables
//   mem_addr_sel : 0 = request address, 1 = victim writeback address
//
// State outputs are decoded from the current state and the array/memory
// status of the same cycle; every output is forced low while rst is high.
module l2_cache_control #(
    parameter int num_ways = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    l2_cache_control_if.slave     bus,
    input  logic                  hit         [num_ways],
    input  logic                  dirty_out   [num_ways],
    input  logic                  valid_out   [num_ways],
    input  logic [num_ways-1:0]   lru_out,
    output logic [num_ways-1:0]   lru_in,
    output logic                  ld_lru,
    output logic                  rd_lru,
    output logic                  ld_dirty    [num_ways],
    output logic                  ld_valid    [num_ways],
    output logic                  ld_tag      [num_ways],
    output logic                  rd_data     [num_ways],
    output logic                  rd_dirty    [num_ways],
    output logic                  rd_valid    [num_ways],
    output logic                  rd_tag      [num_ways],
    output logic                  dirty_in    [num_ways],
    output logic                  valid_in    [num_ways],
    output logic                  datain_sel  [num_ways],
    output logic [31:0]           byte_enable [num_ways],
    output logic                  mem_addr_sel
);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        WB,
        FILL,
        REREAD
    } state_e;

    localparam logic [num_ways-1:0] LSB_ONE = num_ways'(1);

    state_e                state_q;
    logic [num_ways-1:0]   victim_q;

    logic [num_ways-1:0]   hit_vec;
    logic [num_ways-1:0]   valid_vec;
    logic [num_ways-1:0]   dirty_vec;
    logic [num_ways-1:0]   hit_sel;
    logic [num_ways-1:0]   first_invalid;
    logic [num_ways-1:0]   victim_d;
    logic                  any_hit;
    logic                  any_invalid;
    logic                  victim_dirty;
    logic                  req;

    logic                  in_idle;
    logic                  in_check;
    logic                  in_wb;
    logic                  in_fill;
    logic                  in_reread;
    logic                  rd_all;
    logic                  wr_hit;
    logic                  wb_done;
    logic                  fill_done;

    // Flatten the per-way status arrays so one-hot arithmetic can be used.
    for (genvar gi = 0; gi < num_ways; gi++) begin : g_pack
        assign hit_vec[gi]   = hit[gi];
        assign valid_vec[gi] = valid_out[gi];
        assign dirty_vec[gi] = dirty_out[gi];
    end

    assign req          = bus.mem_read | bus.mem_write;
    assign any_hit      = |hit_vec;
    // Isolate the lowest set bit: multiple hits are illegal, but if they
    // ever occur only the lowest way is acted on.
    assign hit_sel      = hit_vec & (~hit_vec + LSB_ONE);
    // Lowest clear bit of the valid vector.
    assign first_invalid = ~valid_vec & (valid_vec + LSB_ONE);
    assign any_invalid  = ~&valid_vec;
    // A zero pointer with every way valid would leave nothing to replace;
    // fall back to way 0 so the miss still makes forward progress.
    assign victim_d     = any_invalid  ? first_invalid :
                          (|lru_out)   ? lru_out       : LSB_ONE;
    assign victim_dirty = |(victim_d & valid_vec & dirty_vec);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            victim_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    if (!req || any_hit) begin
                        state_q <= IDLE;
                    end else begin
                        // Victim is frozen here; WB and FILL keep the
                        // arrays unread so the datapath address stays put.
                        victim_q <= victim_d;
                        state_q  <= victim_dirty ? WB : FILL;
                    end
                end
                WB: begin
                    if (bus.pmem_resp) begin
                        state_q <= FILL;
                    end
                end
                FILL: begin
                    if (bus.pmem_resp) begin
                        state_q <= REREAD;
                    end
                end
                REREAD: begin
                    state_q <= CHECK;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_idle   = !rst && (state_q == IDLE);
    assign in_check  = !rst && (state_q == CHECK);
    assign in_wb     = !rst && (state_q == WB);
    assign in_fill   = !rst && (state_q == FILL);
    assign in_reread = !rst && (state_q == REREAD);

    assign rd_all    = in_idle | in_reread;
    assign wr_hit    = in_check & any_hit & bus.mem_write;
    assign wb_done   = in_wb & bus.pmem_resp;
    assign fill_done = in_fill & bus.pmem_resp;

    assign bus.mem_resp   = in_check & any_hit & req;
    assign bus.pmem_write = in_wb;
    assign bus.pmem_read  = in_fill;
    assign mem_addr_sel   = in_wb;
    assign rd_lru         = rd_all;
    // The replacement pointer only advances when a line is installed; hits
    // leave it alone, giving round-robin order within each set.
    assign ld_lru         = fill_done;

    for (genvar gi = 0; gi < num_ways; gi++) begin : g_way
        logic wr_way;
        logic fill_way;

        assign wr_way   = wr_hit & hit_sel[gi];
        assign fill_way = fill_done & victim_q[gi];

        assign rd_data[gi]     = rd_all;
        assign rd_dirty[gi]    = rd_all;
        assign rd_valid[gi]    = rd_all;
        assign rd_tag[gi]      = rd_all;

        // Dirty bit is set by a write hit and cleared both when the victim
        // has been written back and when the new line is installed.
        assign ld_dirty[gi]    = wr_way | fill_way | (wb_done & victim_q[gi]);
        assign dirty_in[gi]    = wr_way;
        assign ld_valid[gi]    = fill_way;
        assign ld_tag[gi]      = fill_way;
        assign valid_in[gi]    = fill_way;
        assign datain_sel[gi]  = fill_way;
        assign byte_enable[gi] = (wr_way | fill_way) ? 32'hFFFF_FFFF : 32'h0000_0000;

        // Next pointer is the victim rotated left; the top way wraps to 0.
        assign lru_in[gi]      = fill_done & victim_q[(gi + num_ways - 1) % num_ways];
    end

    a_single_hit: assert property (@(posedge clk) disable iff (rst)
        (state_q == CHECK) |-> $onehot0(hit_vec));

    a_pmem_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(bus.pmem_read && bus.pmem_write));

endmodule
